// File: rtl/cv32e40s_data_obi_bridge_if.sv
// OBI data-side bus between the bridge (master) and the memory system (slave).
// A-channel request/payload travel master->slave; grant and R-channel travel back.
interface cv32e40s_data_obi_bridge_if;
    logic        obi_req_o;
    logic        obi_reqpar_o;
    logic [31:0] obi_addr_o;
    logic [31:0] obi_wdata_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [8:0]  obi_achk_o;
    logic        obi_gnt_i;
    logic        obi_gntpar_i;
    logic        obi_rvalid_i;
    logic        obi_rvalidpar_i;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;
    logic [4:0]  obi_rchk_i;

    modport master (
        output obi_req_o, obi_reqpar_o, obi_addr_o, obi_wdata_o, obi_we_o, obi_be_o, obi_achk_o,
        input  obi_gnt_i, obi_gntpar_i, obi_rvalid_i, obi_rvalidpar_i, obi_rdata_i, obi_err_i, obi_rchk_i
    );

    modport slave (
        input  obi_req_o, obi_reqpar_o, obi_addr_o, obi_wdata_o, obi_we_o, obi_be_o, obi_achk_o,
        output obi_gnt_i, obi_gntpar_i, obi_rvalid_i, obi_rvalidpar_i, obi_rdata_i, obi_err_i, obi_rchk_i
    );
endinterface

// File: rtl/cv32e40s_data_obi_bridge.sv
// Data-side OBI bridge: forwards transfers unbuffered, limits outstanding
// transfers, tracks per-transfer attributes in order, and checks handshake
// parity and R-channel check bits to raise integrity errors.
module cv32e40s_data_obi_bridge #(
    parameter int MAX_OUTSTANDING = 2,
    parameter bit RESP_REG        = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trans_valid_i,
    output logic        trans_ready_o,
    input  logic [31:0] trans_addr_i,
    input  logic [31:0] trans_wdata_i,
    input  logic        trans_we_i,
    input  logic [3:0]  trans_be_i,
    input  logic        trans_integrity_i,
    input  logic        integrity_en_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        resp_integrity_err_o,
    output logic        integrity_err_o,
    output logic [3:0]  outstanding_o,
    cv32e40s_data_obi_bridge_if.master obi
);

    localparam logic [3:0] MAX_CNT  = 4'(MAX_OUTSTANDING);
    localparam logic [2:0] LAST_IDX = 3'(MAX_OUTSTANDING - 1);

    // Attribute entry layout: [2] write, [1] integrity requested, [0] grant parity error.
    logic [2:0] fifo_q [8];
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] cnt;

    logic       push;
    logic       pop;
    logic [2:0] head;
    logic       gntpar_err;
    logic       rvalidpar_err;
    logic       rchk_err;
    logic       unexpected_err;
    logic [4:0] rchk_exp;
    logic       resp_integrity_err;

    // A channel: straight pass-through, request gated by the outstanding limit.
    assign obi.obi_req_o    = trans_valid_i && (cnt < MAX_CNT);
    assign obi.obi_reqpar_o = !obi.obi_req_o;
    assign obi.obi_addr_o   = trans_addr_i;
    assign obi.obi_wdata_o  = trans_wdata_i;
    assign obi.obi_we_o     = trans_we_i;
    assign obi.obi_be_o     = trans_be_i;
    assign obi.obi_achk_o   = {^trans_wdata_i[31:24], ^trans_wdata_i[23:16],
                               ^trans_wdata_i[15:8],  ^trans_wdata_i[7:0],
                               ~^{trans_be_i, trans_we_i},
                               ^trans_addr_i[31:24],  ^trans_addr_i[23:16],
                               ^trans_addr_i[15:8],   ^trans_addr_i[7:0]};

    assign trans_ready_o = obi.obi_req_o && obi.obi_gnt_i;
    assign outstanding_o = cnt;

    assign push = obi.obi_req_o && obi.obi_gnt_i;
    assign pop  = obi.obi_rvalid_i && (cnt != 4'd0);
    assign head = pop ? fifo_q[rd_ptr] : 3'b000;

    // Handshake signals and their inverted copies must always disagree.
    assign gntpar_err     = (obi.obi_gnt_i == obi.obi_gntpar_i);
    assign rvalidpar_err  = (obi.obi_rvalid_i == obi.obi_rvalidpar_i);
    assign unexpected_err = obi.obi_rvalid_i && (cnt == 4'd0);

    // Writes carry no read data, so only the error check bit is meaningful for them.
    assign rchk_exp = {^obi.obi_err_i, ^obi.obi_rdata_i[31:24], ^obi.obi_rdata_i[23:16],
                       ^obi.obi_rdata_i[15:8], ^obi.obi_rdata_i[7:0]};
    assign rchk_err = pop && integrity_en_i && head[1] &&
                      (head[2] ? (obi.obi_rchk_i[4] != rchk_exp[4])
                               : (obi.obi_rchk_i != rchk_exp));

    assign resp_integrity_err = obi.obi_rvalid_i &&
                                (rvalidpar_err || head[0] || rchk_err || unexpected_err);
    assign integrity_err_o    = gntpar_err || rvalidpar_err || rchk_err || unexpected_err;

    // Outstanding counter and FIFO pointers; simultaneous grant and response cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 4'd0;
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
        end else begin
            if (push && !pop) begin
                cnt <= cnt + 4'd1;
            end else if (pop && !push) begin
                cnt <= cnt - 4'd1;
            end
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? 3'd0 : wr_ptr + 3'd1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? 3'd0 : rd_ptr + 3'd1;
            end
        end
    end

    // Attribute storage, written at the slot reserved by each grant.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= {trans_we_i, trans_integrity_i, gntpar_err};
        end
    end

    if (RESP_REG) begin : g_resp_reg
        logic        valid_q;
        logic [31:0] rdata_q;
        logic        err_q;
        logic        int_err_q;

        // One-cycle response delay; data/err hold their last value between responses.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q   <= 1'b0;
                rdata_q   <= 32'd0;
                err_q     <= 1'b0;
                int_err_q <= 1'b0;
            end else begin
                valid_q   <= obi.obi_rvalid_i;
                int_err_q <= resp_integrity_err;
                if (obi.obi_rvalid_i) begin
                    rdata_q <= obi.obi_rdata_i;
                    err_q   <= obi.obi_err_i;
                end
            end
        end

        assign resp_valid_o         = valid_q;
        assign resp_rdata_o         = rdata_q;
        assign resp_err_o           = err_q;
        assign resp_integrity_err_o = int_err_q;
    end else begin : g_resp_comb
        assign resp_valid_o         = obi.obi_rvalid_i;
        assign resp_rdata_o         = obi.obi_rdata_i;
        assign resp_err_o           = obi.obi_err_i;
        assign resp_integrity_err_o = resp_integrity_err;
    end

endmodule

// File: tb/tb_cv32e40s_data_obi_bridge.sv
// Bench for the data OBI bridge: two instances (combinational and registered
// response) share one stimulus; a queue-based model checks every cycle, and
// directed tables/sequences pin down the hand-derived corner cases.
module tb_cv32e40s_data_obi_bridge;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst, tv, we, integ, ien, gnt, gntpar, rv, rvpar, err;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic [4:0]  rchk;

    logic        d0_ready, d0_rvalid, d0_err, d0_rint, d0_int;
    logic [31:0] d0_rdata;
    logic [3:0]  d0_out;
    logic        d1_ready, d1_rvalid, d1_err, d1_rint, d1_int;
    logic [31:0] d1_rdata;
    logic [3:0]  d1_out;

    int checks = 0;
    int failures = 0;

    cv32e40s_data_obi_bridge_if bus0 ();
    cv32e40s_data_obi_bridge_if bus1 ();

    assign bus0.obi_gnt_i = gnt;  assign bus0.obi_gntpar_i = gntpar;
    assign bus0.obi_rvalid_i = rv; assign bus0.obi_rvalidpar_i = rvpar;
    assign bus0.obi_rdata_i = rdata; assign bus0.obi_err_i = err; assign bus0.obi_rchk_i = rchk;
    assign bus1.obi_gnt_i = gnt;  assign bus1.obi_gntpar_i = gntpar;
    assign bus1.obi_rvalid_i = rv; assign bus1.obi_rvalidpar_i = rvpar;
    assign bus1.obi_rdata_i = rdata; assign bus1.obi_err_i = err; assign bus1.obi_rchk_i = rchk;

    cv32e40s_data_obi_bridge #(.MAX_OUTSTANDING(MAXO), .RESP_REG(1'b0)) dut0 (
        .clk(clk), .rst(rst), .trans_valid_i(tv), .trans_ready_o(d0_ready),
        .trans_addr_i(addr), .trans_wdata_i(wdata), .trans_we_i(we), .trans_be_i(be),
        .trans_integrity_i(integ), .integrity_en_i(ien), .resp_valid_o(d0_rvalid),
        .resp_rdata_o(d0_rdata), .resp_err_o(d0_err), .resp_integrity_err_o(d0_rint),
        .integrity_err_o(d0_int), .outstanding_o(d0_out), .obi(bus0.master));

    cv32e40s_data_obi_bridge #(.MAX_OUTSTANDING(MAXO), .RESP_REG(1'b1)) dut1 (
        .clk(clk), .rst(rst), .trans_valid_i(tv), .trans_ready_o(d1_ready),
        .trans_addr_i(addr), .trans_wdata_i(wdata), .trans_we_i(we), .trans_be_i(be),
        .trans_integrity_i(integ), .integrity_en_i(ien), .resp_valid_o(d1_rvalid),
        .resp_rdata_o(d1_rdata), .resp_err_o(d1_err), .resp_integrity_err_o(d1_rint),
        .integrity_err_o(d1_int), .outstanding_o(d1_out), .obi(bus1.master));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed { logic we; logic integ; logic gpe; } ent_t;
    ent_t q[$];
    logic        r_valid, r_err, r_int;
    logic [31:0] r_rdata;
    logic        e_req, e_ready, e_int, e_rint, e_pop;
    logic [8:0]  e_achk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        ent_t hd;
        logic gpe, rpe, has, unexp, rce;
        logic [4:0] pe;
        has     = (q.size() > 0);
        hd      = has ? q[0] : ent_t'(3'b000);
        e_req   = tv && (q.size() < MAXO);
        e_ready = e_req && gnt;
        gpe     = (gnt == gntpar);
        rpe     = (rv == rvpar);
        e_pop   = rv && has;
        unexp   = rv && !has;
        pe      = {^err, ^rdata[31:24], ^rdata[23:16], ^rdata[15:8], ^rdata[7:0]};
        rce     = e_pop && ien && hd.integ && (hd.we ? (rchk[4] != pe[4]) : (rchk != pe));
        e_int   = gpe || rpe || rce || unexp;
        e_rint  = rv && (rpe || (e_pop && hd.gpe) || rce || unexp);
        for (int b = 0; b < 4; b++) begin
            e_achk[b]     = ^addr[8*b +: 8];
            e_achk[5 + b] = ^wdata[8*b +: 8];
        end
        e_achk[4] = ~^{be, we};

        chk("d0.req", 32'(bus0.obi_req_o), 32'(e_req));
        chk("d0.reqpar", 32'(bus0.obi_reqpar_o), 32'(!e_req));
        chk("d0.ready", 32'(d0_ready), 32'(e_ready));
        chk("d0.addr", bus0.obi_addr_o, addr);
        chk("d0.wdata", bus0.obi_wdata_o, wdata);
        chk("d0.we_be", 32'({bus0.obi_we_o, bus0.obi_be_o}), 32'({we, be}));
        chk("d0.achk", 32'(bus0.obi_achk_o), 32'(e_achk));
        chk("d0.outstanding", 32'(d0_out), 32'(q.size()));
        chk("d0.integrity_err", 32'(d0_int), 32'(e_int));
        chk("d0.resp_valid", 32'(d0_rvalid), 32'(rv));
        chk("d0.resp_int", 32'(d0_rint), 32'(e_rint));
        if (rv) begin
            chk("d0.resp_rdata", d0_rdata, rdata);
            chk("d0.resp_err", 32'(d0_err), 32'(err));
        end
        chk("d1.req", 32'(bus1.obi_req_o), 32'(e_req));
        chk("d1.ready", 32'(d1_ready), 32'(e_ready));
        chk("d1.achk", 32'(bus1.obi_achk_o), 32'(e_achk));
        chk("d1.outstanding", 32'(d1_out), 32'(q.size()));
        chk("d1.integrity_err", 32'(d1_int), 32'(e_int));
        chk("d1.resp_valid", 32'(d1_rvalid), 32'(r_valid));
        chk("d1.resp_rdata", d1_rdata, r_rdata);
        chk("d1.resp_err", 32'(d1_err), 32'(r_err));
        chk("d1.resp_int", 32'(d1_rint), 32'(r_int));
    endtask

    task automatic model_update();
        if (rst) begin
            q.delete();
            r_valid = 1'b0; r_rdata = 32'd0; r_err = 1'b0; r_int = 1'b0;
        end else begin
            if (e_pop) void'(q.pop_front());
            if (e_ready) q.push_back('{we: we, integ: integ, gpe: (gnt == gntpar)});
            r_valid = rv;
            r_int   = e_rint;
            if (rv) begin
                r_rdata = rdata;
                r_err   = err;
            end
        end
    endtask

    task automatic drive(input logic r, input logic t, input logic w, input logic ig,
                         input logic g, input logic gbad, input logic v, input logic vbad,
                         input logic [31:0] rd, input logic [4:0] rc);
        rst = r; tv = t; we = w; integ = ig; ien = 1'b1;
        gnt = g; gntpar = gbad ? g : !g;
        rv = v; rvpar = vbad ? v : !v;
        rdata = rd; err = 1'b0; rchk = rc;
        addr = $urandom; wdata = $urandom; be = 4'($urandom);
    endtask

    task automatic neg(); @(negedge clk); model_check(); endtask
    task automatic pos(); @(posedge clk); model_update(); #1; endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic rst, tv, we, integ, gnt, gbad, rv, vbad;
        logic [4:0] rchk;
        logic e_req, e_ready, e_int, e_rint;
        int   e_out;
    } vec_t;

    function automatic vec_t mk(logic r, logic t, logic w, logic ig, logic g, logic gb,
                                logic v, logic vb, logic [4:0] rc,
                                logic erq, logic erd, logic ei, logic eri, int eo);
        vec_t x;
        x.rst = r; x.tv = t; x.we = w; x.integ = ig; x.gnt = g; x.gbad = gb;
        x.rv = v; x.vbad = vb; x.rchk = rc;
        x.e_req = erq; x.e_ready = erd; x.e_int = ei; x.e_rint = eri; x.e_out = eo;
        return x;
    endfunction

    vec_t tbl[14];

    initial begin
        logic prev;
        logic cur;
        int   fl;
        //          rst tv we ig gnt gb rv vb rchk      req rdy int rint out
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 1, 1, 0, 0, 0, 5'b00001, 1, 1, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 1, 1, 0, 0, 0, 5'b00001, 1, 1, 0, 0, 1);
        tbl[3]  = mk(0, 1, 0, 1, 1, 0, 0, 0, 5'b00001, 0, 0, 0, 0, 2);
        tbl[4]  = mk(0, 1, 0, 1, 1, 0, 1, 0, 5'b00000, 0, 0, 1, 1, 2);
        tbl[5]  = mk(0, 0, 0, 1, 0, 0, 1, 0, 5'b00001, 0, 0, 0, 0, 1);
        tbl[6]  = mk(0, 1, 1, 0, 1, 1, 0, 0, 5'b00001, 1, 1, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 0, 0, 0, 1, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 0, 0, 1, 1, 0);
        tbl[9]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 5'b00001, 1, 1, 0, 0, 0);
        tbl[10] = mk(1, 1, 0, 0, 0, 0, 0, 0, 5'b00001, 1, 0, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b00001, 0, 0, 1, 1, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 5'b00001, 0, 0, 1, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 0, 0, 0, 0, 0);

        q.delete();
        r_valid = 1'b0; r_rdata = 32'd0; r_err = 1'b0; r_int = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'd1, 5'b00001);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'd1, 5'b00001);
        pos();

        // Reset values of the registered response path.
        neg();
        chk("reset.d1_resp_valid", 32'(d1_rvalid), 32'd0);
        chk("reset.d1_resp_rdata", d1_rdata, 32'd0);
        chk("reset.outstanding", 32'(d0_out), 32'd0);
        pos();

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rst, tbl[i].tv, tbl[i].we, tbl[i].integ, tbl[i].gnt, tbl[i].gbad,
                  tbl[i].rv, tbl[i].vbad, 32'h0000_0001, tbl[i].rchk);
            neg();
            chk($sformatf("tbl%0d.req", i), 32'(bus0.obi_req_o), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d.ready", i), 32'(d0_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d.int", i), 32'(d0_int), 32'(tbl[i].e_int));
            chk($sformatf("tbl%0d.resp_int", i), 32'(d0_rint), 32'(tbl[i].e_rint));
            chk($sformatf("tbl%0d.out", i), 32'(d0_out), 32'(tbl[i].e_out));
            pos();
        end
        neg();
        chk("tbl.after_unexpected_out", 32'(d0_out), 32'd0);
        pos();

        // Grant and response together: count holds, attributes come back in order.
        drive(0, 1, 0, 0, 1, 1, 0, 0, 32'd7, 5'b00000);
        neg();
        chk("b2b.first_grant", 32'(d0_ready), 32'd1);
        pos();
        prev = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cur = (i % 3 == 0);
            drive(0, 1, 0, 0, 1, cur, 1, 0, 32'(i), 5'b00000);
            neg();
            chk($sformatf("b2b%0d.out", i), 32'(d0_out), 32'd1);
            chk($sformatf("b2b%0d.ready", i), 32'(d0_ready), 32'd1);
            chk($sformatf("b2b%0d.order", i), 32'(d0_rint), 32'(prev));
            pos();
            prev = cur;
        end
        drive(0, 0, 0, 0, 0, 0, 1, 0, 32'd9, 5'b00000);
        neg();
        chk("b2b.last_order", 32'(d0_rint), 32'(prev));
        pos();

        // Registered path: responses on N and N+1 appear on N+1 and N+2.
        drive(0, 1, 0, 0, 1, 0, 0, 0, 32'd0, 5'b00000); neg(); pos();
        drive(0, 1, 0, 0, 1, 0, 0, 0, 32'd0, 5'b00000); neg(); pos();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 32'hA5A5_0001, 5'b00000);
        neg();
        chk("rr.N_alert", 32'(d1_int), 32'd1);
        chk("rr.N_valid", 32'(d1_rvalid), 32'd0);
        pos();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h5A5A_0002, 5'b00000);
        neg();
        chk("rr.N1_valid", 32'(d1_rvalid), 32'd1);
        chk("rr.N1_rdata", d1_rdata, 32'hA5A5_0001);
        chk("rr.N1_resp_int", 32'(d1_rint), 32'd1);
        pos();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'b00000);
        neg();
        chk("rr.N2_valid", 32'(d1_rvalid), 32'd1);
        chk("rr.N2_rdata", d1_rdata, 32'h5A5A_0002);
        chk("rr.N2_resp_int", 32'(d1_rint), 32'd0);
        pos();
        neg();
        chk("rr.N3_valid", 32'(d1_rvalid), 32'd0);
        chk("rr.N3_hold", d1_rdata, 32'h5A5A_0002);
        pos();

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rd;
            logic [4:0]  rc;
            logic        v;
            rd = $urandom;
            v  = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 24) == 0),
                  v, ($urandom_range(0, 24) == 0), rd, 5'b00000);
            err  = 1'($urandom);
            ien  = ($urandom_range(0, 3) != 0);
            rchk = {^err, ^rd[31:24], ^rd[23:16], ^rd[15:8], ^rd[7:0]};
            if ($urandom_range(0, 7) == 0) begin
                fl   = $urandom_range(0, 4);
                rchk[fl] = ~rchk[fl];
            end
            neg();
            pos();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
